// File: rtl/bus_addr_decoder.sv
// Shared-bus address decoder: eight active-low chip selects from the top three
// word-address bits, plus registered select state and per-slave access counters.
module bus_addr_decoder #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic              s_as_,
    input  logic              cnt_clr,
    output logic              s0_cs_,
    output logic              s1_cs_,
    output logic              s2_cs_,
    output logic              s3_cs_,
    output logic              s4_cs_,
    output logic              s5_cs_,
    output logic              s6_cs_,
    output logic              s7_cs_,
    output logic [7:0]        cs_q_,
    output logic [2:0]        slv_idx,
    output logic              sel_chg,
    input  logic [2:0]        cnt_sel,
    output logic [CNT_W-1:0]  cnt_val
);

    logic [2:0]       idx;
    logic [7:0]       cs_n;
    logic [CNT_W-1:0] cnt [8];
    logic             unused_addr_bits;

    assign idx              = s_addr[ADDR_W-1 -: 3];
    assign unused_addr_bits = ^s_addr[ADDR_W-4:0];

    // Exactly one select low; independent of clock, reset and strobe.
    always_comb begin
        cs_n      = '1;
        cs_n[idx] = 1'b0;
    end

    assign s0_cs_ = cs_n[0];
    assign s1_cs_ = cs_n[1];
    assign s2_cs_ = cs_n[2];
    assign s3_cs_ = cs_n[3];
    assign s4_cs_ = cs_n[4];
    assign s5_cs_ = cs_n[5];
    assign s6_cs_ = cs_n[6];
    assign s7_cs_ = cs_n[7];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q_   <= 8'hFE;
            slv_idx <= '0;
            sel_chg <= 1'b0;
        end else begin
            cs_q_   <= cs_n;
            slv_idx <= idx;
            sel_chg <= (idx != slv_idx);
        end
    end

    // Clear wins over increment; counters saturate at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (cnt_clr) begin
                    cnt[i] <= '0;
                end else if (!s_as_ && (idx == 3'(i)) && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign cnt_val = cnt[cnt_sel];

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed-vector bench for bus_addr_decoder: decode sweep, boundaries,
// registered path, counters, saturation and asynchronous reset.
module tb_bus_addr_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] s_addr;
    logic        s_as_;
    logic        cnt_clr;
    logic        s0_cs_, s1_cs_, s2_cs_, s3_cs_, s4_cs_, s5_cs_, s6_cs_, s7_cs_;
    logic [7:0]  cs_q_;
    logic [2:0]  slv_idx;
    logic        sel_chg;
    logic [2:0]  cnt_sel;
    logic [15:0] cnt_val;
    logic [7:0]  cs_all;

    int total = 0;
    int bad   = 0;

    bus_addr_decoder #(.ADDR_W(30), .CNT_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_addr  (s_addr),
        .s_as_   (s_as_),
        .cnt_clr (cnt_clr),
        .s0_cs_  (s0_cs_),
        .s1_cs_  (s1_cs_),
        .s2_cs_  (s2_cs_),
        .s3_cs_  (s3_cs_),
        .s4_cs_  (s4_cs_),
        .s5_cs_  (s5_cs_),
        .s6_cs_  (s6_cs_),
        .s7_cs_  (s7_cs_),
        .cs_q_   (cs_q_),
        .slv_idx (slv_idx),
        .sel_chg (sel_chg),
        .cnt_sel (cnt_sel),
        .cnt_val (cnt_val)
    );

    assign cs_all = {s7_cs_, s6_cs_, s5_cs_, s4_cs_, s3_cs_, s2_cs_, s1_cs_, s0_cs_};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_cs(input int n);
        logic [7:0] v;
        v = 8'hFF;
        v[n] = 1'b0;
        return v;
    endfunction

    logic [29:0] sweep_addr [10] = '{30'h0000_0000, 30'h07FF_FFFF, 30'h0FFF_FFFE, 30'h17FF_FFFD,
                                     30'h1FFF_FFFC, 30'h27FF_FFFB, 30'h2FFF_FFFA, 30'h37FF_FFF9,
                                     30'h3FFF_FFF8, 30'h07FF_FFF7};
    int          sweep_slv  [10] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0};
    logic [29:0] bnd_addr   [4]  = '{30'h07FF_FFFF, 30'h0800_0000, 30'h37FF_FFFF, 30'h3800_0000};
    int          bnd_slv    [4]  = '{0, 1, 6, 7};

    initial begin
        reset   = 1'b1;
        s_addr  = '0;
        s_as_   = 1'b1;
        cnt_clr = 1'b0;
        cnt_sel = 3'd0;
        #12;
        check("rst_cs_q", 32'(cs_q_), 32'hFE);
        check("rst_slv_idx", 32'(slv_idx), 0);
        check("rst_sel_chg", 32'(sel_chg), 0);
        check("rst_cnt0", 32'(cnt_val), 0);
        s_addr = 30'h1000_0000;
        #1 check("rst_comb_cs", 32'(cs_all), 32'hFB);
        s_addr = '0;
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk) s_addr = sweep_addr[i];
            #1;
            check($sformatf("sweep%0d_cs", i), 32'(cs_all), 32'(exp_cs(sweep_slv[i])));
            check($sformatf("sweep%0d_onelow", i), 32'($countones(~cs_all)), 1);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk) s_addr = bnd_addr[i];
            #1 check($sformatf("bnd%0d_cs", i), 32'(cs_all), 32'(exp_cs(bnd_slv[i])));
        end

        @(negedge clk) s_addr = 30'h1000_0000;
        @(posedge clk) #1;
        check("reg_cs_q", 32'(cs_q_), 32'hFB);
        check("reg_slv_idx", 32'(slv_idx), 2);
        check("reg_sel_chg1", 32'(sel_chg), 1);
        @(posedge clk) #1;
        check("reg_sel_chg0", 32'(sel_chg), 0);

        @(negedge clk) begin s_addr = 30'h3FFF_FFFF; s_as_ = 1'b0; end
        repeat (5) @(posedge clk);
        @(negedge clk) s_as_ = 1'b1;
        cnt_sel = 3'd7;
        #1 check("cnt7_five", 32'(cnt_val), 5);
        cnt_sel = 3'd0;
        #1 check("cnt0_zero", 32'(cnt_val), 0);
        cnt_sel = 3'd7;
        cnt_clr = 1'b1;
        @(negedge clk) cnt_clr = 1'b0;
        #1 check("cnt7_clr", 32'(cnt_val), 0);
        cnt_clr = 1'b1;
        s_as_   = 1'b0;
        @(negedge clk) begin cnt_clr = 1'b0; s_as_ = 1'b1; end
        #1 check("cnt7_clr_prio", 32'(cnt_val), 0);

        @(negedge clk) begin s_addr = 30'h1800_0000; s_as_ = 1'b0; cnt_sel = 3'd3; end
        repeat (65535) @(posedge clk);
        @(negedge clk) check("cnt3_full", 32'(cnt_val), 32'hFFFF);
        @(negedge clk) s_as_ = 1'b1;
        #1 check("cnt3_sat", 32'(cnt_val), 32'hFFFF);

        @(negedge clk) s_addr = 30'h2800_0000;
        @(posedge clk) #1;
        check("pre_rst_slv_idx", 32'(slv_idx), 5);
        check("pre_rst_cs_q", 32'(cs_q_), 32'hDF);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_cs_q", 32'(cs_q_), 32'hFE);
        check("mid_rst_slv_idx", 32'(slv_idx), 0);
        check("mid_rst_sel_chg", 32'(sel_chg), 0);
        check("mid_rst_cnt3", 32'(cnt_val), 0);
        check("mid_rst_comb5", 32'(cs_all), 32'hDF);
        s_addr = 30'h3000_0000;
        #1 check("mid_rst_comb6", 32'(cs_all), 32'hBF);
        @(posedge clk) #1;
        check("rst_hold_cs_q", 32'(cs_q_), 32'hFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
